// File: rtl/res_stream_out_if.sv
// Handshake bundle between a conv layer's rescaled output, the byte streamer
// and the debug/readout consumer.
interface res_stream_out_if #(
   parameter int BYTES = 40,
   parameter int IDX_W = 6
);
   logic                 data_valid_i;
   logic [8*BYTES-1:0]   data_i;
   logic                 byte_ready_i;
   logic                 ovf_clr_i;
   logic [7:0]           byte_o;
   logic [IDX_W-1:0]     byte_idx_o;
   logic                 byte_valid_o;
   logic                 busy_o;
   logic                 frame_done_o;
   logic                 overrun_o;
   logic [7:0]           drop_cnt_o;

   // Producer / consumer side: drives the vector and ready, observes the stream.
   modport master (
      output data_valid_i, data_i, byte_ready_i, ovf_clr_i,
      input  byte_o, byte_idx_o, byte_valid_o, busy_o, frame_done_o,
      overrun_o, drop_cnt_o
   );

   // Streamer side.
   modport slave (
      input  data_valid_i, data_i, byte_ready_i, ovf_clr_i,
      output byte_o, byte_idx_o, byte_valid_o, busy_o, frame_done_o,
      overrun_o, drop_cnt_o
   );
endinterface

// File: rtl/res_stream_out.sv
// Captures one rescaled conv result vector and streams it out byte by byte
// over a valid/ready handshake, tagging each byte with its index. Strobes
// that arrive while a frame is still in flight are dropped and counted.
module res_stream_out #(
   parameter int BYTES = 40,
   parameter int IDX_W = 6
) (
   input logic         clk,
   input logic         rst_n,
   res_stream_out_if.slave sif
);

   localparam logic [0:0]       ST_IDLE  = 1'b0;
   localparam logic [0:0]       ST_SEND  = 1'b1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

   logic [0:0]          state_q;
   logic [IDX_W-1:0]    idx_q;
   logic                done_q;
   logic                ovf_q;
   logic [7:0]          cnt_q;
   logic [8*BYTES-1:0]  buf_p0;
   logic [8*BYTES-1:0]  buf_sh;
   logic [7:0]          byte_p0;

   logic sending;
   logic xfer;
   logic last;
   logic accept;
   logic drop;

   // Drop counter saturates rather than wrapping so a flood stays visible.
   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // The buffer is kept as a shift register: the next byte to offer is
   // always in the low lane, which avoids a BYTES-wide read mux.
   assign buf_sh  = buf_p0 >> 8;

   assign sending = (state_q == ST_SEND);
   assign xfer    = sending & sif.byte_ready_i;
   assign last    = xfer & (idx_q == LAST_IDX);
   // A strobe coinciding with the final transfer is taken, giving
   // back-to-back frames with no idle bubble.
   assign accept  = sif.data_valid_i & (~sending | last);
   assign drop    = sif.data_valid_i & sending & ~last;

   // Frame sequencing: capture, advance on each handshake, close on last byte.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= last;
         if (accept) begin
            state_q <= ST_SEND;
            idx_q   <= '0;
         end else if (last) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
         end else if (xfer) begin
            idx_q   <= idx_q + IDX_W'(1);
         end
      end
   end

   // Overrun flag and drop count; a clear in the same cycle as a drop keeps
   // the flag low but still records that one drop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
         cnt_q <= '0;
      end else if (sif.ovf_clr_i) begin
         ovf_q <= 1'b0;
         cnt_q <= drop ? 8'd1 : 8'd0;
      end else if (drop) begin
         ovf_q <= 1'b1;
         cnt_q <= sat_inc(cnt_q);
      end
   end

   // Capture buffer: loaded on accept, shifted down one byte per transfer.
   always_ff @(posedge clk) begin
      if (accept) begin
         buf_p0 <= sif.data_i;
      end else if (xfer) begin
         buf_p0 <= buf_sh;
      end
   end

   // Registered output byte; holds while the consumer stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byte_p0 <= '0;
      end else if (accept) begin
         byte_p0 <= sif.data_i[7:0];
      end else if (xfer && !last) begin
         byte_p0 <= buf_sh[7:0];
      end
   end

   assign sif.byte_o       = byte_p0;
   assign sif.byte_idx_o   = idx_q;
   assign sif.byte_valid_o = sending;
   assign sif.busy_o       = sending;
   assign sif.frame_done_o = done_q;
   assign sif.overrun_o    = ovf_q;
   assign sif.drop_cnt_o   = cnt_q;

endmodule

// File: tb/tb_res_stream_out.sv
// Bench for res_stream_out: directed scenarios plus random traffic on a
// 40-byte instance, and a single full frame on a 1152-byte instance.
module tb_res_stream_out;

   localparam int B   = 40;
   localparam int IW  = 6;
   localparam int BB  = 1152;
   localparam int BIW = 11;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   res_stream_out_if #(.BYTES(B),  .IDX_W(IW))  sif ();
   res_stream_out_if #(.BYTES(BB), .IDX_W(BIW)) big ();

   res_stream_out #(.BYTES(B), .IDX_W(IW)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .sif   (sif.slave)
   );

   res_stream_out #(.BYTES(BB), .IDX_W(BIW)) u_big (
      .clk   (clk),
      .rst_n (rst_n),
      .sif   (big.slave)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Scoreboard: expected (idx << 8 | byte) for every byte still to be sent.
   logic [31:0] sb_q[$];
   logic [31:0] mon_e;

   // Reference model: bytes left in the current frame, and status flags.
   int m_rem  = 0;
   int m_done = 0;
   int m_ovf  = 0;
   int m_cnt  = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [8*B-1:0] mk_frame(input int mode);
      logic [8*B-1:0] f;
      for (int k = 0; k < B; k++)
         f[8*k +: 8] = (mode == 1) ? 8'(k + 1) : 8'($urandom);
      return f;
   endfunction

   // Monitor: every accepted byte is checked against the scoreboard head.
   always @(negedge clk) begin
      if (rst_n && sif.byte_valid_o && sif.byte_ready_i) begin
         if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_empty: byte idx %0d offered with nothing expected", sif.byte_idx_o);
         end else begin
            mon_e = sb_q.pop_front();
            chk("byte_idx", int'(sif.byte_idx_o), int'(mon_e[15:8]));
            chk("byte_val", int'(sif.byte_o), int'(mon_e[7:0]));
         end
      end
   end

   // One clock of stimulus; entered and left at posedge+1.
   task automatic step(input logic dv, input logic [8*B-1:0] d,
                       input logic rdy, input logic clr);
      int xfer, last, accept, drop;
      sif.data_valid_i = dv;
      sif.data_i       = d;
      sif.byte_ready_i = rdy;
      sif.ovf_clr_i    = clr;
      xfer   = (m_rem > 0 && rdy) ? 1 : 0;
      last   = (xfer == 1 && m_rem == 1) ? 1 : 0;
      accept = (dv && (m_rem == 0 || last == 1)) ? 1 : 0;
      drop   = (dv && accept == 0) ? 1 : 0;
      @(negedge clk);
      chk("byte_valid", int'(sif.byte_valid_o), (m_rem > 0) ? 1 : 0);
      chk("busy",       int'(sif.busy_o),       (m_rem > 0) ? 1 : 0);
      chk("frame_done", int'(sif.frame_done_o), m_done);
      chk("overrun",    int'(sif.overrun_o),    m_ovf);
      chk("drop_cnt",   int'(sif.drop_cnt_o),   m_cnt);
      @(posedge clk);
      if (xfer == 1) m_rem--;
      m_done = last;
      if (accept == 1) begin
         for (int k = 0; k < B; k++)
            sb_q.push_back((32'(k) << 8) | 32'(d[8*k +: 8]));
         m_rem = B;
      end
      if (clr) begin
         m_ovf = 0;
         m_cnt = (drop == 1) ? 1 : 0;
      end else if (drop == 1) begin
         m_ovf = 1;
         if (m_cnt < 255) m_cnt++;
      end
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_byte"},  int'(sif.byte_o),       0);
      chk({tag, "_idx"},   int'(sif.byte_idx_o),   0);
      chk({tag, "_valid"}, int'(sif.byte_valid_o), 0);
      chk({tag, "_busy"},  int'(sif.busy_o),       0);
      chk({tag, "_done"},  int'(sif.frame_done_o), 0);
      chk({tag, "_ovf"},   int'(sif.overrun_o),    0);
      chk({tag, "_cnt"},   int'(sif.drop_cnt_o),   0);
   endtask

   // Asynchronous reset in the middle of a clock period.
   task automatic async_reset();
      #2 rst_n = 1'b0;
      #1 chk_all_zero("rst_mid");
      m_rem  = 0;
      m_done = 0;
      m_ovf  = 0;
      m_cnt  = 0;
      sb_q.delete();
      sif.data_valid_i = 1'b0;
      sif.ovf_clr_i    = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      logic [8*B-1:0]  f;
      logic [8*BB-1:0] bf;

      sif.data_valid_i = 1'b0;
      sif.data_i       = '0;
      sif.byte_ready_i = 1'b0;
      sif.ovf_clr_i    = 1'b0;
      big.data_valid_i = 1'b0;
      big.data_i       = '0;
      big.byte_ready_i = 1'b0;
      big.ovf_clr_i    = 1'b0;

      #1 chk_all_zero("reset");
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Ready while idle is ignored.
      repeat (3) step(1'b0, '0, 1'b1, 1'b0);

      // Entry k = k+1, ready held high.
      f = mk_frame(1);
      step(1'b1, f, 1'b1, 1'b0);
      repeat (44) step(1'b0, '0, 1'b1, 1'b0);

      // Same frame, ready toggling every cycle.
      step(1'b1, f, 1'b0, 1'b0);
      for (int i = 0; i < 90; i++) step(1'b0, '0, (i % 2 == 0), 1'b0);

      // Drop at idx 10, back-to-back accept on the last transfer.
      step(1'b1, mk_frame(0), 1'b1, 1'b0);
      for (int i = 0; i < B; i++)
         step((m_rem == 30 || m_rem == 1), mk_frame(0), 1'b1, 1'b0);
      repeat (42) step(1'b0, '0, 1'b1, 1'b0);
      step(1'b0, '0, 1'b1, 1'b1);
      step(1'b0, '0, 1'b1, 1'b0);

      // Flood of strobes during a stalled frame saturates the drop count.
      step(1'b1, mk_frame(0), 1'b0, 1'b0);
      repeat (300) step(1'b1, mk_frame(0), 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, 1'b1);
      step(1'b0, '0, 1'b0, 1'b0);
      repeat (42) step(1'b0, '0, 1'b1, 1'b0);

      // Reset mid-frame at idx 20; no strobe afterwards keeps the block idle.
      step(1'b1, mk_frame(0), 1'b1, 1'b0);
      while (m_rem > 20) step(1'b0, '0, 1'b1, 1'b0);
      async_reset();
      repeat (6) step(1'b0, '0, 1'b1, 1'b0);

      // Random traffic.
      for (int i = 0; i < 1500; i++)
         step(($urandom % 16) == 0, mk_frame(0), ($urandom % 3) != 0,
              ($urandom % 50) == 0);
      repeat (45) step(1'b0, '0, 1'b1, 1'b0);
      chk("sb_drained", sb_q.size(), 0);

      // Large instance: entry k = k[7:0], ready held high.
      for (int k = 0; k < BB; k++) bf[8*k +: 8] = 8'(k);
      big.data_i       = bf;
      big.data_valid_i = 1'b1;
      big.byte_ready_i = 1'b1;
      @(posedge clk);
      #1 big.data_valid_i = 1'b0;
      for (int i = 0; i < BB; i++) begin
         @(negedge clk);
         chk("big_valid", int'(big.byte_valid_o), 1);
         chk("big_idx",   int'(big.byte_idx_o),   i);
         chk("big_byte",  int'(big.byte_o),       i % 256);
         chk("big_done",  int'(big.frame_done_o), 0);
      end
      @(negedge clk);
      chk("big_done_end",  int'(big.frame_done_o), 1);
      chk("big_valid_end", int'(big.byte_valid_o), 0);
      @(negedge clk);
      chk("big_done_once", int'(big.frame_done_o), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/res_stream_out.md
Name: res_stream_out

Overview:
- Output-side companion to the per-layer result selector.
- Captures one wide rescaled conv result vector when its valid strobe fires, then streams it out byte by byte over a valid/ready handshake with a byte index.
- Lets a host or debug link read a whole layer output in order, instead of picking single bytes with a select input.
- Sits between a conv layer's rescaled output (conv1/conv2/conv3 *_rescaled buses) and the debug/readout port.

Parameters:
- BYTES, 40, number of 8-bit entries in the captured vector (40 conv1, 1152 conv2, 36 conv3).
- IDX_W, 6, width of byte index; must satisfy 2^IDX_W >= BYTES (11 for conv2).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- data_valid_i  input  1  one-cycle strobe: data_i holds a complete rescaled vector.
- data_i  input  8*BYTES  rescaled vector; entry k = data_i[8k+7:8k].
- byte_ready_i  input  1  downstream accepts byte_o this cycle.
- ovf_clr_i  input  1  synchronous clear of overrun_o and drop_cnt_o.
- byte_o  output  8  current entry being offered.
- byte_idx_o  output  IDX_W  index of byte_o within the frame.
- byte_valid_o  output  1  byte_o/byte_idx_o valid.
- busy_o  output  1  a frame is held or being streamed.
- frame_done_o  output  1  one-cycle pulse after the last byte transfers.
- overrun_o  output  1  sticky; a strobe arrived while busy and was dropped.
- drop_cnt_o  output  8  count of dropped frames, saturating at 255.

Behaviour:
- Reset (rst_n low, async): state IDLE; all outputs 0; capture buffer contents don't-care.
- States: IDLE, SEND.
- IDLE:
  - data_valid_i=1 -> capture data_i into buffer, idx=0, go to SEND.
  - Next cycle: byte_valid_o=1, byte_idx_o=0, byte_o=entry 0. Capture-to-first-byte latency is 1 cycle.
- SEND:
  - byte_valid_o=1 and busy_o=1 throughout.
  - Transfer occurs when byte_valid_o & byte_ready_i. On transfer, idx increments and byte_o/byte_idx_o update next cycle.
  - Without ready, byte_o and byte_idx_o hold stable; valid is never withdrawn.
  - Transfer at idx=BYTES-1: frame_done_o=1 next cycle (single cycle), state returns to IDLE, byte_valid_o=0, busy_o=0. idx never exceeds BYTES-1.
- Strobe while in SEND, not on the last transfer: frame dropped, buffer untouched, overrun_o set, drop_cnt_o += 1 (holds at 255).
- Strobe in the same cycle as the last-byte transfer: accepted, no drop. The new vector is captured; next cycle frame_done_o=1 and SEND restarts at idx 0 with byte_valid_o=1 (back-to-back, zero bubble).
- ovf_clr_i: clears overrun_o and drop_cnt_o next cycle. If a drop occurs in the same cycle, clear wins for overrun_o, and drop_cnt_o loads 1.
- byte_ready_i while not valid: ignored.
- Reset asserted mid-frame: stream aborts immediately; no frame_done_o pulse; after release, wait in IDLE for a fresh strobe.
- Output bytes are byte_o = buffer[8*idx +: 8], registered; no combinational path from data_i to outputs.
- Throughput with ready held high: BYTES cycles per frame, plus 1 capture cycle from IDLE.

Test Plan:
- BYTES=40, entry k = k+1, ready held 1, one strobe -> cycles 1..40 give byte_o=1..40, byte_idx_o=0..39; frame_done_o pulses at cycle 41; busy_o=0 after.
- Same frame, ready toggled 1/0 every cycle -> same 40 bytes in order, each held stable while ready=0; frame_done_o after 80 cycles.
- Strobe at idx=10, then strobe at idx=39 coincident with the last transfer:
  - First strobe dropped: overrun_o=1, drop_cnt_o=1.
  - Second accepted: frame_done_o and byte_idx_o=0 with the new entry 0 in the same cycle.
- 300 strobes during one long stalled frame (ready=0) -> drop_cnt_o saturates at 255. Then ovf_clr_i -> overrun_o=0, drop_cnt_o=0.
- rst_n low at idx=20 -> all outputs 0 asynchronously; no frame_done_o. After release with no strobe, byte_valid_o stays 0.
- BYTES=1152, IDX_W=11, entry k = k[7:0] -> byte_idx_o reaches 1151 with byte_o=0x7F; frame_done_o after 1152 transfers.
